// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, keeps one request outstanding to
// instruction memory and presents the buffered word (or a NOP bubble) to IF/ID.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD,
        S_DISCARD
    } state_e;

    state_e      state_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] addr_q;
    logic [31:0] buf_pc_q;
    logic [31:0] buf_instr_q;
    logic [31:0] redirect_tgt;

    // Redirect targets are forced word-aligned; the low two bits are ignored.
    assign redirect_tgt = redirect_pc & ~32'h0000_0003;

    // addr_q tracks the outstanding request, so it stays put in DISCARD even
    // though fetch_pc_q already points at the new path.
    assign imem_req    = (state_q == S_WAIT) || (state_q == S_DISCARD);
    assign imem_addr   = addr_q;
    assign instr_valid = (state_q == S_HOLD);
    assign pc          = (state_q == S_HOLD) ? buf_pc_q    : fetch_pc_q;
    assign instr       = (state_q == S_HOLD) ? buf_instr_q : NOP;

    // NOTE: non-blocking assignments throughout, so every branch below reads
    // the pre-edge values of the registers it updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= RESET_PC;
            addr_q      <= RESET_PC;
            buf_pc_q    <= RESET_PC;
            buf_instr_q <= NOP;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_WAIT;
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_tgt;
                        addr_q     <= redirect_tgt;
                    end else begin
                        addr_q     <= fetch_pc_q;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_tgt;
                        if (imem_ack) begin
                            addr_q  <= redirect_tgt;
                            state_q <= S_WAIT;
                        end else begin
                            state_q <= S_DISCARD;
                        end
                    end else if (imem_ack) begin
                        buf_pc_q    <= fetch_pc_q;
                        buf_instr_q <= imem_rdata;
                        state_q     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_tgt;
                        addr_q     <= redirect_tgt;
                        state_q    <= S_WAIT;
                    end else if (!stall) begin
                        fetch_pc_q <= buf_pc_q + 32'd4;
                        addr_q     <= buf_pc_q + 32'd4;
                        state_q    <= S_WAIT;
                    end
                end
                S_DISCARD: begin
                    // A stale ack retires the old request; the latest target wins.
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_tgt;
                        if (imem_ack) begin
                            addr_q  <= redirect_tgt;
                            state_q <= S_WAIT;
                        end
                    end else if (imem_ack) begin
                        addr_q  <= fetch_pc_q;
                        state_q <= S_WAIT;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, sequential fetch, stall, redirects,
// alignment and PC wrap, with hand-computed expectations.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;

    int n_checks = 0;
    int n_fail   = 0;

    if_fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .pc            (pc),
        .instr         (instr),
        .instr_valid   (instr_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock edge; inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                              input logic valid, input logic [31:0] exp_pc,
                              input logic [31:0] exp_instr);
        check({tag, ".req"},   {31'd0, imem_req},    {31'd0, req});
        if (req)
            check({tag, ".addr"}, imem_addr, addr);
        check({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, valid});
        check({tag, ".pc"},    pc,    exp_pc);
        check({tag, ".instr"}, instr, exp_instr);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        @(negedge clk);

        // 1: reset state, then first request one edge after release
        repeat (3) tick();
        expect_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
        reset = 1'b0;
        tick();
        expect_out("first_req", 1'b1, 32'h0, 1'b0, 32'h0, NOP);

        // 2: sequential fetch, ack one cycle after each request
        tick();
        expect_out("wait_a", 1'b1, 32'h0, 1'b0, 32'h0, NOP);
        imem_ack = 1'b1; imem_rdata = 32'h0000_000A;
        tick();
        expect_out("hold_a", 1'b0, 32'h0, 1'b1, 32'h0, 32'h0000_000A);
        imem_ack = 1'b0;
        tick();
        expect_out("req_4", 1'b1, 32'h4, 1'b0, 32'h4, NOP);
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h0000_000B;
        tick();
        expect_out("hold_b", 1'b0, 32'h0, 1'b1, 32'h4, 32'h0000_000B);

        // 3: stall in HOLD keeps outputs stable, release resumes at +4
        imem_ack = 1'b0; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("stall%0d", i), 1'b0, 32'h0, 1'b1, 32'h4, 32'h0000_000B);
        end
        stall = 1'b0;
        tick();
        expect_out("req_8", 1'b1, 32'h8, 1'b0, 32'h8, NOP);
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h0000_000C;
        tick();
        expect_out("hold_c", 1'b0, 32'h0, 1'b1, 32'h8, 32'h0000_000C);
        imem_ack = 1'b0;
        tick();
        expect_out("req_c", 1'b1, 32'hC, 1'b0, 32'hC, NOP);

        // 4: redirect while waiting; old address held until the stale ack
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        expect_out("discard0", 1'b1, 32'hC, 1'b0, 32'h100, NOP);
        redirect_valid = 1'b0;
        tick();
        expect_out("discard1", 1'b1, 32'hC, 1'b0, 32'h100, NOP);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        expect_out("req_100", 1'b1, 32'h100, 1'b0, 32'h100, NOP);
        imem_rdata = 32'h0000_0011;
        tick();
        expect_out("hold_100", 1'b0, 32'h0, 1'b1, 32'h100, 32'h0000_0011);
        imem_ack = 1'b0;

        // 5: redirect beats stall in HOLD
        redirect_valid = 1'b1; stall = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        expect_out("redir_hold", 1'b1, 32'h200, 1'b0, 32'h200, NOP);
        redirect_valid = 1'b0; stall = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h0000_0022;
        tick();
        expect_out("hold_200", 1'b0, 32'h0, 1'b1, 32'h200, 32'h0000_0022);
        imem_ack = 1'b0;

        // 6: misaligned target is aligned; redirect with ack drops data; PC wraps
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        expect_out("align", 1'b1, 32'h100, 1'b0, 32'h100, NOP);
        redirect_pc = 32'hFFFF_FFFF; imem_ack = 1'b1; imem_rdata = 32'h0000_0055;
        tick();
        expect_out("redir_ack", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, NOP);
        redirect_valid = 1'b0; imem_rdata = 32'h0000_0033;
        tick();
        expect_out("hold_top", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0033);
        imem_ack = 1'b0;
        tick();
        expect_out("wrap", 1'b1, 32'h0, 1'b0, 32'h0, NOP);

        // Reset mid-request abandons the transaction
        reset = 1'b1;
        tick();
        expect_out("mid_reset", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
        reset = 1'b0;
        tick();
        expect_out("post_reset", 1'b1, 32'h0, 1'b0, 32'h0, NOP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
